// File: rtl/ahb_pkg.sv
// Shared AHB encodings and default-subordinate state type
// for the data-phase response mux.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE,
    DS_ERR1,
    DS_ERR2
  } ds_state_t;

endpackage

// File: rtl/ahb_resp_mux_if.sv
// Bus bundle between the decoders/subordinates/manager and
// the response mux; the mux takes the slave view.
interface ahb_resp_mux_if #(
  parameter int NSLV    = 8,
  parameter int XLEN    = 64,
  parameter int PA_BITS = 56
);

  logic [NSLV-1:0]      HSELRegions;
  logic [1:0]           HTRANS;
  logic [PA_BITS-1:0]   HADDR;
  logic [NSLV*XLEN-1:0] HRDATAS;
  logic [NSLV-1:0]      HREADYS;
  logic [NSLV-1:0]      HRESPS;
  logic [XLEN-1:0]      HRDATA;
  logic                 HREADY;
  logic                 HRESP;
  logic                 ErrValid;
  logic [PA_BITS-1:0]   ErrAddr;
  logic                 ErrClear;

  modport slave (
    input  HSELRegions,
    input  HTRANS,
    input  HADDR,
    input  HRDATAS,
    input  HREADYS,
    input  HRESPS,
    input  ErrClear,
    output HRDATA,
    output HREADY,
    output HRESP,
    output ErrValid,
    output ErrAddr
  );

  modport master (
    output HSELRegions,
    output HTRANS,
    output HADDR,
    output HRDATAS,
    output HREADYS,
    output HRESPS,
    output ErrClear,
    input  HRDATA,
    input  HREADY,
    input  HRESP,
    input  ErrValid,
    input  ErrAddr
  );

endinterface

// File: rtl/ahb_default_slave.sv
// Default subordinate: two-cycle ERROR for unmapped transfers.
// Optional first-error capture under AHB_ERR_CAPTURE_EN.
module ahb_default_slave
  import ahb_pkg::*;
#(
  parameter int PA_BITS = 56
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_accept,
  input  logic               i_unmapped,
  input  logic [PA_BITS-1:0] i_haddr,
  input  logic               i_err_clear,
  output logic               o_hready,
  output logic               o_hresp,
  output logic               o_err_valid,
  output logic [PA_BITS-1:0] o_err_addr
);

  ds_state_t r_state;
  ds_state_t w_next;
  logic      w_err_ev;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= DS_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      DS_IDLE: begin
        if (i_accept && i_unmapped) w_next = DS_ERR1;
      end
      DS_ERR1: w_next = DS_ERR2;
      DS_ERR2: begin
        if (i_accept && i_unmapped) w_next = DS_ERR1;
        else                        w_next = DS_IDLE;
      end
      default: w_next = DS_IDLE;
    endcase
  end

  always_comb begin
    o_hready = 1'b1;
    o_hresp  = HRESP_OKAY;
    unique case (r_state)
      DS_IDLE: begin
        o_hready = 1'b1;
        o_hresp  = HRESP_OKAY;
      end
      DS_ERR1: begin
        o_hready = 1'b0;
        o_hresp  = HRESP_ERROR;
      end
      DS_ERR2: begin
        o_hready = 1'b1;
        o_hresp  = HRESP_ERROR;
      end
      default: begin
        o_hready = 1'b1;
        o_hresp  = HRESP_OKAY;
      end
    endcase
  end

  // ERR1 is never re-entered from ERR1, so this marks a new error
  assign w_err_ev = (w_next == DS_ERR1);

`ifdef AHB_ERR_CAPTURE_EN
  logic               r_err_valid;
  logic [PA_BITS-1:0] r_err_addr;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
    end else if (w_err_ev && (!r_err_valid || i_err_clear)) begin
      r_err_valid <= 1'b1;
      r_err_addr  <= i_haddr;
    end else if (i_err_clear) begin
      r_err_valid <= 1'b0;
    end
  end

  assign o_err_valid = r_err_valid;
  assign o_err_addr  = r_err_addr;
`else
  logic w_unused;

  assign w_unused    = ^{i_haddr, i_err_clear, w_err_ev};
  assign o_err_valid = 1'b0;
  assign o_err_addr  = '0;
`endif

endmodule

// File: rtl/ahb_resp_mux.sv
// AHB data-phase response mux with built-in default subordinate.
// Define AHB_ERR_CAPTURE_EN to add the unmapped-address capture regs.
module ahb_resp_mux
  import ahb_pkg::*;
#(
  parameter int NSLV    = 8,
  parameter int XLEN    = 64,
  parameter int PA_BITS = 56
) (
  input logic          HCLK,
  input logic          HRESETn,
  ahb_resp_mux_if.slave bus
);

  logic [NSLV-1:0] r_hseld;
  logic [NSLV-1:0] w_sel_pri;
  logic            w_unmapped;
  logic            w_accept;
  logic            w_ds_ready;
  logic            w_ds_resp;
  logic [XLEN-1:0] w_rdata;
  logic            w_ready;
  logic            w_resp;

  // isolate lowest set bit so multi-hot selects resolve to one slice
  assign w_sel_pri  = bus.HSELRegions
                    & (~bus.HSELRegions + NSLV'(1));
  assign w_unmapped = bus.HTRANS[1] & ~|bus.HSELRegions;
  assign w_accept   = w_ready;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_hseld <= '0;
    end else if (w_accept) begin
      r_hseld <= bus.HTRANS[1] ? w_sel_pri : '0;
    end
  end

  always_comb begin
    w_rdata = '0;
    w_ready = w_ds_ready;
    w_resp  = w_ds_resp;
    for (int i = 0; i < NSLV; i++) begin
      if (r_hseld[i]) begin
        w_rdata = bus.HRDATAS[i*XLEN +: XLEN];
        w_ready = bus.HREADYS[i];
        w_resp  = bus.HRESPS[i];
      end
    end
  end

  assign bus.HRDATA = w_rdata;
  assign bus.HREADY = w_ready;
  assign bus.HRESP  = w_resp;

  ahb_default_slave #(
    .PA_BITS(PA_BITS)
  ) u_dflt (
    .i_clk       (HCLK),
    .i_rst_n     (HRESETn),
    .i_accept    (w_accept),
    .i_unmapped  (w_unmapped),
    .i_haddr     (bus.HADDR),
    .i_err_clear (bus.ErrClear),
    .o_hready    (w_ds_ready),
    .o_hresp     (w_ds_resp),
    .o_err_valid (bus.ErrValid),
    .o_err_addr  (bus.ErrAddr)
  );

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Scoreboard bench for ahb_resp_mux; capture expectations
// follow AHB_ERR_CAPTURE_EN.
module tb_ahb_resp_mux;
  import ahb_pkg::*;

  localparam int NSLV = 8;
  localparam int XLEN = 64;
  localparam int PA   = 56;
`ifdef AHB_ERR_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  typedef struct {
    logic [1:0]  tr;
    logic [7:0]  sel;
    logic [55:0] addr;
    logic        clr;
    logic        rn;
    logic [7:0]  rdys;
    logic [7:0]  rsps;
  } st_t;

  typedef struct {
    logic        rdy;
    logic        rsp;
    logic [63:0] dat;
    logic        ev;
    logic [55:0] ea;
  } ex_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ahb_resp_mux_if #(.NSLV(NSLV), .XLEN(XLEN), .PA_BITS(PA)) bus ();

  ahb_resp_mux #(.NSLV(NSLV), .XLEN(XLEN), .PA_BITS(PA)) dut (
    .HCLK    (clk),
    .HRESETn (rst_n),
    .bus     (bus)
  );

  ex_t sb[$];
  int errs = 0;
  int checks = 0;
  logic [63:0] slv [NSLV];

  localparam logic [55:0] A1 = 56'h0000_0800_0000;
  localparam logic [55:0] A2 = 56'h0000_1000_0000;
  localparam logic [55:0] A3 = 56'h0000_2000_0040;
  localparam logic [55:0] A4 = 56'h0000_3000_0000;
  localparam logic [55:0] A5 = 56'h0000_4000_0100;

  function automatic st_t st(input logic [1:0] tr, input logic [7:0] sel,
                             input logic [55:0] addr = '0, input logic clr = 1'b0,
                             input logic rn = 1'b1, input logic [7:0] rdys = 8'hFF,
                             input logic [7:0] rsps = 8'h00);
    st_t s;
    s.tr = tr; s.sel = sel; s.addr = addr; s.clr = clr;
    s.rn = rn; s.rdys = rdys; s.rsps = rsps;
    return s;
  endfunction

  function automatic ex_t ex(input logic rdy, input logic rsp, input logic [63:0] dat,
                             input logic ev, input logic [55:0] ea);
    ex_t e;
    e.rdy = rdy; e.rsp = rsp; e.dat = dat;
    e.ev = ev & CAP;
    e.ea = CAP ? ea : '0;
    return e;
  endfunction

  task automatic drive(input st_t s);
    @(negedge clk);
    rst_n            = s.rn;
    bus.HTRANS       = s.tr;
    bus.HSELRegions  = s.sel;
    bus.HADDR        = s.addr;
    bus.ErrClear     = s.clr;
    bus.HREADYS      = s.rdys;
    bus.HRESPS       = s.rsps;
    for (int i = 0; i < NSLV; i++) bus.HRDATAS[i*XLEN +: XLEN] = slv[i];
  endtask

  task automatic test_reset();
    st_t s[$];
    ex_t e[$];
    ex_t x;
    for (int i = 0; i < 2; i++) begin
      s.push_back(st(2'($urandom), 8'($urandom), {24'($urandom), 32'($urandom)},
                     1'($urandom), 1'b0, 8'($urandom), 8'($urandom)));
      e.push_back(ex(1'b1, 1'b0, '0, 1'b0, '0));
    end
    s.push_back(st(HTRANS_IDLE, 8'h00));
    e.push_back(ex(1'b1, 1'b0, '0, 1'b0, '0));
    foreach (s[i]) begin
      drive(s[i]); sb.push_back(e[i]); #1; x = sb.pop_front(); checks++;
      if ({bus.HREADY, bus.HRESP, bus.HRDATA, bus.ErrValid, bus.ErrAddr} !==
          {x.rdy, x.rsp, x.dat, x.ev, x.ea}) begin
        errs++;
        $display("FAIL reset[%0d]: got rdy=%b rsp=%b dat=%h ev=%b ea=%h want rdy=%b rsp=%b dat=%h ev=%b ea=%h",
                 i, bus.HREADY, bus.HRESP, bus.HRDATA, bus.ErrValid, bus.ErrAddr,
                 x.rdy, x.rsp, x.dat, x.ev, x.ea);
      end
    end
  endtask

  task automatic test_mapped();
    st_t s[$];
    ex_t e[$];
    ex_t x;
    slv[2] = 64'hDEAD_BEEF_0123_4567;
    s.push_back(st(HTRANS_NONSEQ, 8'h04));
    e.push_back(ex(1'b1, 1'b0, '0, 1'b0, '0));
    s.push_back(st(HTRANS_IDLE, 8'h00, '0, 1'b0, 1'b1, 8'hFB));
    e.push_back(ex(1'b0, 1'b0, slv[2], 1'b0, '0));
    s.push_back(st(HTRANS_IDLE, 8'h00, '0, 1'b0, 1'b1, 8'hFB));
    e.push_back(ex(1'b0, 1'b0, slv[2], 1'b0, '0));
    s.push_back(st(HTRANS_IDLE, 8'h00));
    e.push_back(ex(1'b1, 1'b0, slv[2], 1'b0, '0));
    s.push_back(st(HTRANS_IDLE, 8'h00));
    e.push_back(ex(1'b1, 1'b0, '0, 1'b0, '0));
    foreach (s[i]) begin
      drive(s[i]); sb.push_back(e[i]); #1; x = sb.pop_front(); checks++;
      if ({bus.HREADY, bus.HRESP, bus.HRDATA, bus.ErrValid, bus.ErrAddr} !==
          {x.rdy, x.rsp, x.dat, x.ev, x.ea}) begin
        errs++;
        $display("FAIL mapped[%0d]: got rdy=%b rsp=%b dat=%h ev=%b ea=%h want rdy=%b rsp=%b dat=%h ev=%b ea=%h",
                 i, bus.HREADY, bus.HRESP, bus.HRDATA, bus.ErrValid, bus.ErrAddr,
                 x.rdy, x.rsp, x.dat, x.ev, x.ea);
      end
    end
  endtask

  task automatic test_unmapped();
    st_t s[$];
    ex_t e[$];
    ex_t x;
    s.push_back(st(HTRANS_NONSEQ, 8'h00, A1));
    e.push_back(ex(1'b1, 1'b0, '0, 1'b0, '0));
    s.push_back(st(HTRANS_IDLE, 8'h00));
    e.push_back(ex(1'b0, 1'b1, '0, 1'b1, A1));
    s.push_back(st(HTRANS_IDLE, 8'h00));
    e.push_back(ex(1'b1, 1'b1, '0, 1'b1, A1));
    s.push_back(st(HTRANS_IDLE, 8'h00, '0, 1'b1));
    e.push_back(ex(1'b1, 1'b0, '0, 1'b1, A1));
    s.push_back(st(HTRANS_IDLE, 8'h00));
    e.push_back(ex(1'b1, 1'b0, '0, 1'b0, A1));
    foreach (s[i]) begin
      drive(s[i]); sb.push_back(e[i]); #1; x = sb.pop_front(); checks++;
      if ({bus.HREADY, bus.HRESP, bus.HRDATA, bus.ErrValid, bus.ErrAddr} !==
          {x.rdy, x.rsp, x.dat, x.ev, x.ea}) begin
        errs++;
        $display("FAIL unmapped[%0d]: got rdy=%b rsp=%b dat=%h ev=%b ea=%h want rdy=%b rsp=%b dat=%h ev=%b ea=%h",
                 i, bus.HREADY, bus.HRESP, bus.HRDATA, bus.ErrValid, bus.ErrAddr,
                 x.rdy, x.rsp, x.dat, x.ev, x.ea);
      end
    end
  endtask

  task automatic test_back_to_back();
    st_t s[$];
    ex_t e[$];
    ex_t x;
    s.push_back(st(HTRANS_NONSEQ, 8'h00, A2));
    e.push_back(ex(1'b1, 1'b0, '0, 1'b0, A1));
    s.push_back(st(HTRANS_SEQ, 8'h00, A2 + 56'd8));
    e.push_back(ex(1'b0, 1'b1, '0, 1'b1, A2));
    s.push_back(st(HTRANS_SEQ, 8'h00, A2 + 56'd8));
    e.push_back(ex(1'b1, 1'b1, '0, 1'b1, A2));
    s.push_back(st(HTRANS_IDLE, 8'h00));
    e.push_back(ex(1'b0, 1'b1, '0, 1'b1, A2));
    s.push_back(st(HTRANS_IDLE, 8'h00));
    e.push_back(ex(1'b1, 1'b1, '0, 1'b1, A2));
    s.push_back(st(HTRANS_IDLE, 8'h00, '0, 1'b1));
    e.push_back(ex(1'b1, 1'b0, '0, 1'b1, A2));
    s.push_back(st(HTRANS_IDLE, 8'h00));
    e.push_back(ex(1'b1, 1'b0, '0, 1'b0, A2));
    foreach (s[i]) begin
      drive(s[i]); sb.push_back(e[i]); #1; x = sb.pop_front(); checks++;
      if ({bus.HREADY, bus.HRESP, bus.HRDATA, bus.ErrValid, bus.ErrAddr} !==
          {x.rdy, x.rsp, x.dat, x.ev, x.ea}) begin
        errs++;
        $display("FAIL b2b[%0d]: got rdy=%b rsp=%b dat=%h ev=%b ea=%h want rdy=%b rsp=%b dat=%h ev=%b ea=%h",
                 i, bus.HREADY, bus.HRESP, bus.HRDATA, bus.ErrValid, bus.ErrAddr,
                 x.rdy, x.rsp, x.dat, x.ev, x.ea);
      end
    end
  endtask

  task automatic test_idle_multihot();
    st_t s[$];
    ex_t e[$];
    ex_t x;
    s.push_back(st(HTRANS_IDLE, 8'h00));
    e.push_back(ex(1'b1, 1'b0, '0, 1'b0, A2));
    s.push_back(st(HTRANS_IDLE, 8'h04));
    e.push_back(ex(1'b1, 1'b0, '0, 1'b0, A2));
    s.push_back(st(HTRANS_BUSY, 8'h00));
    e.push_back(ex(1'b1, 1'b0, '0, 1'b0, A2));
    s.push_back(st(HTRANS_NONSEQ, 8'h0A));
    e.push_back(ex(1'b1, 1'b0, '0, 1'b0, A2));
    s.push_back(st(HTRANS_IDLE, 8'h00, '0, 1'b0, 1'b1, 8'hF7, 8'h02));
    e.push_back(ex(1'b1, 1'b1, slv[1], 1'b0, A2));
    s.push_back(st(HTRANS_IDLE, 8'h00));
    e.push_back(ex(1'b1, 1'b0, '0, 1'b0, A2));
    foreach (s[i]) begin
      drive(s[i]); sb.push_back(e[i]); #1; x = sb.pop_front(); checks++;
      if ({bus.HREADY, bus.HRESP, bus.HRDATA, bus.ErrValid, bus.ErrAddr} !==
          {x.rdy, x.rsp, x.dat, x.ev, x.ea}) begin
        errs++;
        $display("FAIL idle_mh[%0d]: got rdy=%b rsp=%b dat=%h ev=%b ea=%h want rdy=%b rsp=%b dat=%h ev=%b ea=%h",
                 i, bus.HREADY, bus.HRESP, bus.HRDATA, bus.ErrValid, bus.ErrAddr,
                 x.rdy, x.rsp, x.dat, x.ev, x.ea);
      end
    end
  endtask

  task automatic test_reset_err1();
    st_t s[$];
    ex_t e[$];
    ex_t x;
    s.push_back(st(HTRANS_NONSEQ, 8'h00, A3));
    e.push_back(ex(1'b1, 1'b0, '0, 1'b0, A2));
    s.push_back(st(HTRANS_IDLE, 8'h00, '0, 1'b0, 1'b0));
    e.push_back(ex(1'b0, 1'b1, '0, 1'b1, A3));
    s.push_back(st(HTRANS_IDLE, 8'h00));
    e.push_back(ex(1'b1, 1'b0, '0, 1'b0, '0));
    s.push_back(st(HTRANS_IDLE, 8'h00));
    e.push_back(ex(1'b1, 1'b0, '0, 1'b0, '0));
    foreach (s[i]) begin
      drive(s[i]); sb.push_back(e[i]); #1; x = sb.pop_front(); checks++;
      if ({bus.HREADY, bus.HRESP, bus.HRDATA, bus.ErrValid, bus.ErrAddr} !==
          {x.rdy, x.rsp, x.dat, x.ev, x.ea}) begin
        errs++;
        $display("FAIL rst_err1[%0d]: got rdy=%b rsp=%b dat=%h ev=%b ea=%h want rdy=%b rsp=%b dat=%h ev=%b ea=%h",
                 i, bus.HREADY, bus.HRESP, bus.HRDATA, bus.ErrValid, bus.ErrAddr,
                 x.rdy, x.rsp, x.dat, x.ev, x.ea);
      end
    end
  endtask

  task automatic test_clear_race();
    st_t s[$];
    ex_t e[$];
    ex_t x;
    s.push_back(st(HTRANS_NONSEQ, 8'h00, A4));
    e.push_back(ex(1'b1, 1'b0, '0, 1'b0, '0));
    s.push_back(st(HTRANS_IDLE, 8'h00));
    e.push_back(ex(1'b0, 1'b1, '0, 1'b1, A4));
    s.push_back(st(HTRANS_NONSEQ, 8'h00, A5, 1'b1));
    e.push_back(ex(1'b1, 1'b1, '0, 1'b1, A4));
    s.push_back(st(HTRANS_IDLE, 8'h00));
    e.push_back(ex(1'b0, 1'b1, '0, 1'b1, A5));
    s.push_back(st(HTRANS_IDLE, 8'h00));
    e.push_back(ex(1'b1, 1'b1, '0, 1'b1, A5));
    s.push_back(st(HTRANS_IDLE, 8'h00));
    e.push_back(ex(1'b1, 1'b0, '0, 1'b1, A5));
    foreach (s[i]) begin
      drive(s[i]); sb.push_back(e[i]); #1; x = sb.pop_front(); checks++;
      if ({bus.HREADY, bus.HRESP, bus.HRDATA, bus.ErrValid, bus.ErrAddr} !==
          {x.rdy, x.rsp, x.dat, x.ev, x.ea}) begin
        errs++;
        $display("FAIL clr_race[%0d]: got rdy=%b rsp=%b dat=%h ev=%b ea=%h want rdy=%b rsp=%b dat=%h ev=%b ea=%h",
                 i, bus.HREADY, bus.HRESP, bus.HRDATA, bus.ErrValid, bus.ErrAddr,
                 x.rdy, x.rsp, x.dat, x.ev, x.ea);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NSLV; i++) slv[i] = {$urandom, $urandom} | 64'h1;
    slv[1] = 64'h1111_2222_3333_4444;
    slv[3] = 64'h9999_AAAA_BBBB_CCCC;
    bus.HTRANS      = HTRANS_IDLE;
    bus.HSELRegions = '0;
    bus.HADDR       = '0;
    bus.ErrClear    = 1'b0;
    bus.HREADYS     = '1;
    bus.HRESPS      = '0;
    bus.HRDATAS     = '0;
    test_reset();
    test_mapped();
    test_unmapped();
    test_back_to_back();
    test_idle_multihot();
    test_reset_err1();
    test_clear_race();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
